// File: rtl/bus_cycle_decoder.sv
// rtl/bus_cycle_decoder.sv - turns filtered cartridge-bus cycles into single req/ack transactions
module bus_cycle_decoder #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255,
    parameter int WAIT_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sltsl_n,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic          req,
    output logic          req_io,
    output logic          req_wr,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_wdata,
    input  logic          ack,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] dout,
    output logic          data_oe,
    output logic          wait_n,
    output logic          err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          req_nxt, req_io_nxt, req_wr_nxt;
    logic [AW-1:0] req_addr_nxt;
    logic [DW-1:0] req_wdata_nxt, dout_nxt;
    logic          data_oe_nxt, wait_n_nxt, err_nxt;
    logic          start, strobe_released;

    // Both strobes low is a malformed cycle and is simply not started.
    assign start = ((~mreq_n & ~sltsl_n) | ~iorq_n) & (rd_n ^ wr_n);
    assign strobe_released = req_wr ? wr_n : rd_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req       <= 1'b0;
            req_io    <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            dout      <= '0;
            data_oe   <= 1'b0;
            wait_n    <= 1'b1;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req       <= req_nxt;
            req_io    <= req_io_nxt;
            req_wr    <= req_wr_nxt;
            req_addr  <= req_addr_nxt;
            req_wdata <= req_wdata_nxt;
            dout      <= dout_nxt;
            data_oe   <= data_oe_nxt;
            wait_n    <= wait_n_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_nxt       = req;
        req_io_nxt    = req_io;
        req_wr_nxt    = req_wr;
        req_addr_nxt  = req_addr;
        req_wdata_nxt = req_wdata;
        dout_nxt      = dout;
        data_oe_nxt   = data_oe;
        wait_n_nxt    = wait_n;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    req_addr_nxt = addr;
                    if (!wr_n) req_wdata_nxt = din;
                    req_io_nxt   = ~iorq_n;
                    req_wr_nxt   = ~wr_n;
                    req_nxt      = 1'b1;
                    wait_n_nxt   = (WAIT_EN == 0);
                    cnt_nxt      = '0;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                cnt_nxt = cnt + CW'(1);
                // Ack wins over a timeout landing on the same edge.
                if (ack) begin
                    req_nxt    = 1'b0;
                    wait_n_nxt = 1'b1;
                    state_nxt  = HOLD;
                    if (!req_wr && !strobe_released) begin
                        dout_nxt    = rdata;
                        data_oe_nxt = 1'b1;
                    end else begin
                        data_oe_nxt = 1'b0;
                    end
                    err_nxt = strobe_released;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    req_nxt    = 1'b0;
                    wait_n_nxt = 1'b1;
                    err_nxt    = 1'b1;
                    state_nxt  = HOLD;
                    if (!req_wr) begin
                        dout_nxt    = {DW{1'b1}};
                        data_oe_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rd_n && wr_n) begin
                    data_oe_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
